// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer.
//   DATA_W      : operand / register width
//   aluFunc_t   : ALU operation encodings (FN_ADD .. FN_PASS)
//   seqState_t  : sequencer FSM states
//   funcUpdatesCarry() : which operations are allowed to change the carry flag
package alu_op_sequencer_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    FN_ADD  = 3'd0,
    FN_SUB  = 3'd1,
    FN_AND  = 3'd2,
    FN_OR   = 3'd3,
    FN_XOR  = 3'd4,
    FN_NOT  = 3'd5,
    FN_SRA1 = 3'd6,
    FN_PASS = 3'd7
  } aluFunc_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } seqState_t;

  // Only the arithmetic and shift operations produce a meaningful carry;
  // the logical operations leave the flag alone.
  function automatic logic funcUpdatesCarry(input aluFunc_t f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_SRA1);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_alu.sv
// Purely combinational ALU used by the sequencer.
//   a, b  : operands (b unused by NOT, SRA1 and PASS)
//   func  : operation select
//   cin   : carry / borrow in (ADD and SUB only)
//   y     : 32-bit result
//   cout  : carry out of ADD, borrow out of SUB, shifted-out bit of SRA1;
//           zero for the logical operations
module alu_op_sequencer_alu
  import alu_op_sequencer_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  aluFunc_t          func,
  input  logic              cin,
  output logic [DATA_W-1:0] y,
  output logic              cout
);

  logic [DATA_W:0] wide;

  // One 33-bit adder/subtractor path covers ADD and SUB so the carry and
  // borrow both fall out as bit 32; every other op is a simple bitwise map.
  always_comb begin
    wide = '0;
    y    = a;
    cout = 1'b0;
    case (func)
      FN_ADD: begin
        wide = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
        y    = wide[DATA_W-1:0];
        cout = wide[DATA_W];
      end
      FN_SUB: begin
        wide = {1'b0, a} - {1'b0, b} - {{DATA_W{1'b0}}, cin};
        y    = wide[DATA_W-1:0];
        cout = wide[DATA_W];
      end
      FN_AND:  y = a & b;
      FN_OR:   y = a | b;
      FN_XOR:  y = a ^ b;
      FN_NOT:  y = ~a;
      FN_SRA1: begin
        y    = {a[DATA_W-1], a[DATA_W-1:1]};
        cout = a[0];
      end
      FN_PASS: y = a;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Four-state ALU command sequencer with a local register file.
//   clk, rst          : clock and asynchronous active-high reset
//   cmd_*             : command handshake (func, operand/destination indices,
//                       carry-in enable); accepted only in IDLE without a load
//   ld_en/addr/data   : host register load, honoured only in IDLE
//   rd_addr/rd_data   : combinational host read port
//   busy, done        : command in flight / one-cycle writeback pulse
//   carry, result     : carry flag and last written-back value
// A command takes IDLE -> READ -> EXEC -> WRITE, so done fires three cycles
// after the handshake and a new command can be taken every fourth cycle.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter  int NREGS = 8,
  localparam int IW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_func,
  input  logic [IW-1:0]     cmd_src_a,
  input  logic [IW-1:0]     cmd_src_b,
  input  logic [IW-1:0]     cmd_dst,
  input  logic              cmd_use_carry,
  input  logic              ld_en,
  input  logic [IW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [IW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              carry,
  output logic [DATA_W-1:0] result
);

  seqState_t state, nextState;

  logic [DATA_W-1:0] regs [NREGS];

  aluFunc_t          funcQ;
  logic [IW-1:0]     srcAQ, srcBQ, dstQ;
  logic              useCarryQ;
  logic [DATA_W-1:0] opA, opB;
  logic [DATA_W-1:0] execResult;
  logic              execCarry;
  logic [DATA_W-1:0] resultQ;
  logic              carryQ;

  logic [DATA_W-1:0] aluY;
  logic              aluCout;
  logic              cmdReady;
  logic              handshake;

  assign handshake = cmd_valid && cmdReady;
  assign cmd_ready = cmdReady;
  assign rd_data   = regs[rd_addr];
  assign carry     = carryQ;
  assign result    = resultQ;

  // The carry flag only reaches the ALU when the command asked for it.
  alu_op_sequencer_alu uAlu (
    .a    (opA),
    .b    (opB),
    .func (funcQ),
    .cin  (useCarryQ & carryQ),
    .y    (aluY),
    .cout (aluCout)
  );

  // State register; reset drops any in-flight command straight back to IDLE,
  // which is what suppresses its writeback and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nextState;
  end

  // Next-state and status decode. A host load in IDLE takes priority over a
  // command, so ready is withheld for that cycle and the command waits.
  always_comb begin
    nextState = state;
    cmdReady  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        busy     = 1'b0;
        cmdReady = !ld_en;
        if (cmd_valid && !ld_en) nextState = ST_READ;
      end
      ST_READ:  nextState = ST_EXEC;
      ST_EXEC:  nextState = ST_WRITE;
      ST_WRITE: begin
        done      = 1'b1;
        nextState = ST_IDLE;
      end
      default:  nextState = ST_IDLE;
    endcase
  end

  // Datapath pipeline: capture the command at the handshake, snapshot the
  // operands in READ (so a destination that aliases a source still sees the
  // old value), register the ALU output in EXEC, and publish result/carry in
  // WRITE. Everything holds its value while the sequencer sits in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      funcQ      <= FN_ADD;
      srcAQ      <= '0;
      srcBQ      <= '0;
      dstQ       <= '0;
      useCarryQ  <= 1'b0;
      opA        <= '0;
      opB        <= '0;
      execResult <= '0;
      execCarry  <= 1'b0;
      resultQ    <= '0;
      carryQ     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (handshake) begin
            funcQ     <= aluFunc_t'(cmd_func);
            srcAQ     <= cmd_src_a;
            srcBQ     <= cmd_src_b;
            dstQ      <= cmd_dst;
            useCarryQ <= cmd_use_carry;
          end
        end
        ST_READ: begin
          opA <= regs[srcAQ];
          opB <= regs[srcBQ];
        end
        ST_EXEC: begin
          execResult <= aluY;
          execCarry  <= aluCout;
        end
        ST_WRITE: begin
          resultQ <= execResult;
          if (funcUpdatesCarry(funcQ)) carryQ <= execCarry;
        end
        default: ;
      endcase
    end
  end

  // Single register-file write port shared by host loads and writeback.
  // The two sources can never collide because loads are only honoured in
  // IDLE and writeback only happens in WRITE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (state == ST_IDLE && ld_en) begin
      regs[ld_addr] <= ld_data;
    end else if (state == ST_WRITE) begin
      regs[dstQ] <= execResult;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer. Each command is issued
// through applyStimulus, which also checks the handshake and the fixed
// three-cycle latency; register contents, carry and result are compared
// against hand-computed constants afterwards.
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  localparam int NREGS = 8;
  localparam int IW    = 3;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_func;
  logic [IW-1:0]     cmd_src_a;
  logic [IW-1:0]     cmd_src_b;
  logic [IW-1:0]     cmd_dst;
  logic              cmd_use_carry;
  logic              ld_en;
  logic [IW-1:0]     ld_addr;
  logic [31:0]       ld_data;
  logic [IW-1:0]     rd_addr;
  logic [31:0]       rd_data;
  logic              busy;
  logic              done;
  logic              carry;
  logic [31:0]       result;

  int errors = 0;
  int checks = 0;
  logic watchDone = 1'b0;
  logic doneSeen  = 1'b0;

  alu_op_sequencer #(.NREGS(NREGS)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_func      (cmd_func),
    .cmd_src_a     (cmd_src_a),
    .cmd_src_b     (cmd_src_b),
    .cmd_dst       (cmd_dst),
    .cmd_use_carry (cmd_use_carry),
    .ld_en         (ld_en),
    .ld_addr       (ld_addr),
    .ld_data       (ld_data),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .busy          (busy),
    .done          (done),
    .carry         (carry),
    .result        (result)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records any done pulse while the reset-abort scenario is being watched.
  always @(negedge clk) begin
    if (watchDone && done) doneSeen = 1'b1;
  end

  // Hard stop in case something wedges the bench.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic stepCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic checkReg(input string tag, input logic [IW-1:0] addr,
                          input logic [31:0] expected);
    rd_addr = addr;
    #1;
    checkOutput(tag, rd_data, expected);
  endtask

  task automatic loadReg(input logic [IW-1:0] addr, input logic [31:0] data);
    ld_en   = 1'b1;
    ld_addr = addr;
    ld_data = data;
    stepCycle();
    ld_en   = 1'b0;
  endtask

  // Issues one command, checks ready, busy and the handshake-to-done latency,
  // then steps past WRITE so the writeback is visible. ldWhileBusy holds a
  // host load of 0xDEADBEEF into r2 for the whole time the command is busy.
  task automatic applyStimulus(input string tag, input logic [2:0] func,
                               input logic [IW-1:0] a, input logic [IW-1:0] b,
                               input logic [IW-1:0] dst, input logic useCarry,
                               input logic ldWhileBusy);
    int lat;
    cmd_valid     = 1'b1;
    cmd_func      = func;
    cmd_src_a     = a;
    cmd_src_b     = b;
    cmd_dst       = dst;
    cmd_use_carry = useCarry;
    #1;
    checkOutput({tag, "/ready"}, 32'(cmd_ready), 32'd1);
    stepCycle();
    cmd_valid = 1'b0;
    checkOutput({tag, "/busy"}, 32'(busy), 32'd1);
    if (ldWhileBusy) begin
      ld_en   = 1'b1;
      ld_addr = 3'd2;
      ld_data = 32'hDEADBEEF;
    end
    lat = 1;
    while (!done && lat < 10) begin
      stepCycle();
      lat++;
    end
    checkOutput({tag, "/latency"}, 32'(lat), 32'd3);
    stepCycle();
    ld_en = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    cmd_valid     = 1'b0;
    cmd_func      = 3'd0;
    cmd_src_a     = '0;
    cmd_src_b     = '0;
    cmd_dst       = '0;
    cmd_use_carry = 1'b0;
    ld_en         = 1'b0;
    ld_addr       = '0;
    ld_data       = '0;
    rd_addr       = '0;

    // Reset state
    repeat (2) stepCycle();
    checkOutput("rst/busy", 32'(busy), 32'd0);
    checkOutput("rst/done", 32'(done), 32'd0);
    checkOutput("rst/carry", 32'(carry), 32'd0);
    checkOutput("rst/result", result, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rst/readyAfter", 32'(cmd_ready), 32'd1);
    checkReg("rst/r1", 3'd1, 32'd0);

    // ADD with carry out, then ADD using carry-in
    loadReg(3'd1, 32'hFFFFFFFF);
    loadReg(3'd2, 32'h00000001);
    checkReg("load/r1", 3'd1, 32'hFFFFFFFF);
    applyStimulus("add1", 3'd0, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0);
    checkReg("add1/r3", 3'd3, 32'h00000000);
    checkOutput("add1/carry", 32'(carry), 32'd1);
    checkOutput("add1/result", result, 32'h00000000);
    applyStimulus("add2", 3'd0, 3'd3, 3'd3, 3'd4, 1'b1, 1'b0);
    checkReg("add2/r4", 3'd4, 32'h00000001);
    checkOutput("add2/carry", 32'(carry), 32'd0);
    checkOutput("add2/result", result, 32'h00000001);

    // SUB with borrow, then SUB with borrow-in and dst aliasing src_b
    loadReg(3'd5, 32'd5);
    loadReg(3'd6, 32'd7);
    applyStimulus("sub1", 3'd1, 3'd5, 3'd6, 3'd7, 1'b0, 1'b0);
    checkReg("sub1/r7", 3'd7, 32'hFFFFFFFE);
    checkOutput("sub1/carry", 32'(carry), 32'd1);
    applyStimulus("sub2", 3'd1, 3'd1, 3'd2, 3'd2, 1'b1, 1'b0);
    checkReg("sub2/r2", 3'd2, 32'hFFFFFFFD);
    checkOutput("sub2/carry", 32'(carry), 32'd0);

    // SRA1 in place, then logical ops that must leave carry alone
    loadReg(3'd0, 32'h80000001);
    applyStimulus("sra1", 3'd6, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    checkReg("sra1/r0", 3'd0, 32'hC0000000);
    checkOutput("sra1/carry", 32'(carry), 32'd1);
    applyStimulus("and", 3'd2, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    checkReg("and/r0", 3'd0, 32'hC0000000);
    checkOutput("and/carry", 32'(carry), 32'd1);
    applyStimulus("not", 3'd5, 3'd1, 3'd7, 3'd5, 1'b0, 1'b0);
    checkReg("not/r5", 3'd5, 32'h00000000);
    applyStimulus("xor", 3'd4, 3'd7, 3'd1, 3'd6, 1'b0, 1'b0);
    checkReg("xor/r6", 3'd6, 32'h00000001);
    checkOutput("xor/carry", 32'(carry), 32'd1);

    // Host load while busy is ignored
    applyStimulus("pass", 3'd7, 3'd7, 3'd2, 3'd3, 1'b0, 1'b1);
    checkReg("pass/r3", 3'd3, 32'hFFFFFFFE);
    checkReg("busyLoad/r2", 3'd2, 32'hFFFFFFFD);
    checkOutput("pass/result", result, 32'hFFFFFFFE);

    // Load and command together: load wins, command taken next cycle
    ld_en         = 1'b1;
    ld_addr       = 3'd4;
    ld_data       = 32'h00001234;
    cmd_valid     = 1'b1;
    cmd_func      = 3'd3;
    cmd_src_a     = 3'd4;
    cmd_src_b     = 3'd0;
    cmd_dst       = 3'd5;
    cmd_use_carry = 1'b0;
    #1;
    checkOutput("ldCmd/readyLow", 32'(cmd_ready), 32'd0);
    stepCycle();
    ld_en = 1'b0;
    checkOutput("ldCmd/notBusy", 32'(busy), 32'd0);
    checkReg("ldCmd/r4", 3'd4, 32'h00001234);
    applyStimulus("or", 3'd3, 3'd4, 3'd0, 3'd5, 1'b0, 1'b0);
    checkReg("or/r5", 3'd5, 32'hC0001234);
    checkOutput("or/carry", 32'(carry), 32'd1);

    // Reset during EXEC aborts the command
    cmd_valid     = 1'b1;
    cmd_func      = 3'd0;
    cmd_src_a     = 3'd1;
    cmd_src_b     = 3'd2;
    cmd_dst       = 3'd3;
    cmd_use_carry = 1'b0;
    stepCycle();
    cmd_valid = 1'b0;
    stepCycle();
    checkOutput("abort/busyExec", 32'(busy), 32'd1);
    watchDone = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort/busy", 32'(busy), 32'd0);
    checkOutput("abort/carry", 32'(carry), 32'd0);
    stepCycle();
    stepCycle();
    rst = 1'b0;
    #1;
    checkOutput("abort/ready", 32'(cmd_ready), 32'd1);
    repeat (3) stepCycle();
    watchDone = 1'b0;
    checkOutput("abort/doneSeen", 32'(doneSeen), 32'd0);
    checkReg("abort/r3", 3'd3, 32'h00000000);
    checkReg("abort/r1", 3'd1, 32'h00000000);
    checkOutput("abort/result", result, 32'h00000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
